// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer.
// Register selects, CTRL bit positions and channel state.
package timer_pkg;

    localparam logic [1:0] CTRL   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] COUNT  = 2'd2;
    localparam logic [1:0] STATUS = 2'd3;

    localparam int EN   = 0;
    localparam int MODE = 1;
    localparam int IE   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: CTRL/LOAD/COUNT/STATUS
// registers and the IDLE/RUN state machine.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             we_ctrl,
    input  logic             we_load,
    input  logic             we_status,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] load,
    output logic [2:0]       ctrl,
    output logic             pending,
    output logic             expire
);

    ch_state_e state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ctrl    <= '0;
            load    <= '0;
            count   <= '0;
            pending <= 1'b0;
            expire  <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (we_load)
                load <= wdata;
            if (we_status && wdata[0])
                pending <= 1'b0;
            if (we_ctrl)
                ctrl <= wdata[2:0];
            unique case (state)
                IDLE: begin
                    if (we_ctrl && wdata[EN]) begin
                        state <= RUN;
                        count <= load;
                    end
                end
                RUN: begin
                    if (we_ctrl && !wdata[EN]) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (count != '0) begin
                            count <= count - 1'b1;
                        end else begin
                            // expiry beats a same-edge STATUS clear
                            expire  <= 1'b1;
                            pending <= 1'b1;
                            if (ctrl[MODE]) begin
                                count <= load;
                            end else begin
                                ctrl[EN] <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/timer_multi.sv
// Multi-channel timer: shared prescaler, register decode,
// registered read mux and combined interrupt.
module timer_multi
    import timer_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 16,
    parameter int PRESC_DIV = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [$clog2(NUM_CH)+1:0] addr,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic [NUM_CH-1:0]         expire,
    output logic                      irq
);

    localparam int AW = $clog2(NUM_CH) + 2;
    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

    logic [PW-1:0]    presc;
    logic             tick;
    logic [AW-1:0]    chsel;
    logic [1:0]       rsel;
    logic [WIDTH-1:0] cnt [NUM_CH];
    logic [WIDTH-1:0] ld  [NUM_CH];
    logic [2:0]       ctl [NUM_CH];
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] ie;
    logic [NUM_CH-1:0] hit;
    logic [WIDTH-1:0] rnext;

    assign tick  = (presc == PW'(PRESC_DIV - 1));
    assign chsel = addr >> 2;
    assign rsel  = addr[1:0];

    always_ff @(posedge clk) begin
        if (!rst)
            presc <= '0;
        else
            presc <= tick ? '0 : presc + 1'b1;
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign hit[gi] = we && (chsel == AW'(gi));
        assign ie[gi]  = ctl[gi][IE];
        timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .we_ctrl   (hit[gi] && rsel == CTRL),
            .we_load   (hit[gi] && rsel == LOAD),
            .we_status (hit[gi] && rsel == STATUS),
            .wdata     (wdata),
            .count     (cnt[gi]),
            .load      (ld[gi]),
            .ctrl      (ctl[gi]),
            .pending   (pend[gi]),
            .expire    (expire[gi])
        );
    end

    // out-of-range channels match no entry and read 0
    always_comb begin
        rnext = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chsel == AW'(i)) begin
                unique case (rsel)
                    CTRL:    rnext = WIDTH'(ctl[i]);
                    LOAD:    rnext = ld[i];
                    COUNT:   rnext = cnt[i];
                    STATUS:  rnext = WIDTH'(pend[i]);
                    default: rnext = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
            irq   <= 1'b0;
        end else begin
            rdata <= rnext;
            irq   <= |(pend & ie);
        end
    end

endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: two instances (4ch/div1, 3ch/div4)
// checked against queued expectations.
module tb_timer_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, we_a, irq_a;
    logic [3:0]  addr_a, expire_a;
    logic [15:0] wdata_a, rdata_a;

    logic        rst_b, we_b, irq_b;
    logic [3:0]  addr_b;
    logic [2:0]  expire_b;
    logic [15:0] wdata_b, rdata_b;

    timer_multi #(.NUM_CH(4), .WIDTH(16), .PRESC_DIV(1)) dut_a (
        .clk(clk), .rst(rst_a), .we(we_a), .addr(addr_a),
        .wdata(wdata_a), .rdata(rdata_a), .expire(expire_a), .irq(irq_a)
    );

    timer_multi #(.NUM_CH(3), .WIDTH(16), .PRESC_DIV(4)) dut_b (
        .clk(clk), .rst(rst_b), .we(we_b), .addr(addr_b),
        .wdata(wdata_b), .rdata(rdata_b), .expire(expire_b), .irq(irq_b)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [15:0] d);
        we_a = 1'b1; addr_a = a; wdata_a = d;
        step();
        we_a = 1'b0;
    endtask

    task automatic wr_b(input logic [3:0] a, input logic [15:0] d);
        we_b = 1'b1; addr_b = a; wdata_b = d;
        step();
        we_b = 1'b0;
    endtask

    function automatic logic [15:0] cnt_model(input int j);
        if (j <= 10) return 16'(10 - j);
        return (j % 2 == 1) ? 16'd1 : 16'd0;
    endfunction

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0;
        step(); step();
        rst_a = 1'b1; rst_b = 1'b1;
        checks++;
        if (rdata_a !== 16'h0) begin
            failures++; $display("FAIL reset_rdata_a got=%h exp=0", rdata_a);
        end
        checks++;
        if (rdata_b !== 16'h0) begin
            failures++; $display("FAIL reset_rdata_b got=%h exp=0", rdata_b);
        end
        checks++;
        if (expire_a !== 4'h0 || expire_b !== 3'h0) begin
            failures++; $display("FAIL reset_expire got=%h/%h exp=0", expire_a, expire_b);
        end
        checks++;
        if (irq_a !== 1'b0 || irq_b !== 1'b0) begin
            failures++; $display("FAIL reset_irq got=%b/%b exp=0", irq_a, irq_b);
        end
        for (int a = 0; a < 16; a++) begin
            addr_a = 4'(a);
            exp_q.push_back(16'h0);
            step();
            e = exp_q.pop_front();
            checks++;
            if (rdata_a !== e) begin
                failures++; $display("FAIL reset_reg a=%0d got=%h exp=%h", a, rdata_a, e);
            end
        end
    endtask

    task automatic test_oneshot();
        wr_a(4'd1, 16'd3);
        we_a = 1'b1; addr_a = 4'd0; wdata_a = 16'h1;
        step();
        we_a = 1'b0; addr_a = 4'd2;
        for (int k = 1; k <= 6; k++) begin
            exp_q.push_back(k <= 4 ? 16'(4 - k) : 16'd0);
            step();
            e = exp_q.pop_front();
            checks++;
            if (rdata_a !== e) begin
                failures++; $display("FAIL oneshot_count k=%0d got=%h exp=%h", k, rdata_a, e);
            end
            checks++;
            if (expire_a !== (k == 4 ? 4'b0001 : 4'b0000)) begin
                failures++; $display("FAIL oneshot_expire k=%0d got=%b", k, expire_a);
            end
            checks++;
            if (irq_a !== 1'b0) begin
                failures++; $display("FAIL oneshot_irq k=%0d got=%b exp=0", k, irq_a);
            end
        end
        addr_a = 4'd0;
        step();
        checks++;
        if (rdata_a !== 16'h0) begin
            failures++; $display("FAIL oneshot_en got=%h exp=0", rdata_a);
        end
        addr_a = 4'd3;
        step();
        checks++;
        if (rdata_a !== 16'h1) begin
            failures++; $display("FAIL oneshot_pending got=%h exp=1", rdata_a);
        end
        wr_a(4'd3, 16'h1);
    endtask

    task automatic test_periodic();
        logic xirq;
        wr_a(4'd5, 16'd2);
        we_a = 1'b1; addr_a = 4'd4; wdata_a = 16'h7;
        step();
        for (int k = 1; k <= 16; k++) begin
            we_a = 1'b0; addr_a = 4'd7;
            if (k == 10 || k == 15) begin
                we_a = 1'b1; wdata_a = 16'h1;
            end
            if (k == 11) exp_q.push_back(16'h0);
            if (k == 16) exp_q.push_back(16'h1);
            step();
            if (k == 11 || k == 16) begin
                e = exp_q.pop_front();
                checks++;
                if (rdata_a !== e) begin
                    failures++; $display("FAIL periodic_pending k=%0d got=%h exp=%h", k, rdata_a, e);
                end
            end
            checks++;
            if (expire_a !== {2'b00, (k % 3 == 0), 1'b0}) begin
                failures++; $display("FAIL periodic_expire k=%0d got=%b", k, expire_a);
            end
            xirq = (k >= 4 && k <= 10) || k >= 13;
            checks++;
            if (irq_a !== xirq) begin
                failures++; $display("FAIL periodic_irq k=%0d got=%b exp=%b", k, irq_a, xirq);
            end
        end
        we_a = 1'b0;
        wr_a(4'd4, 16'h0);
        wr_a(4'd7, 16'h1);
        step();
        checks++;
        if (irq_a !== 1'b0) begin
            failures++; $display("FAIL periodic_irq_clear got=%b exp=0", irq_a);
        end
    endtask

    task automatic test_reload();
        wr_a(4'd13, 16'd10);
        we_a = 1'b1; addr_a = 4'd12; wdata_a = 16'h3;
        step();
        for (int k = 1; k <= 17; k++) begin
            we_a = 1'b0; addr_a = 4'd14;
            if (k == 3) begin
                we_a = 1'b1; addr_a = 4'd13; wdata_a = 16'd1;
            end
            if (k == 5) begin
                we_a = 1'b1; addr_a = 4'd12; wdata_a = 16'h3;
            end
            if (k != 3 && k != 5) exp_q.push_back(cnt_model(k - 1));
            step();
            if (k != 3 && k != 5) begin
                e = exp_q.pop_front();
                checks++;
                if (rdata_a !== e) begin
                    failures++; $display("FAIL reload_count k=%0d got=%h exp=%h", k, rdata_a, e);
                end
            end
            checks++;
            if (expire_a !== ((k == 11 || k == 13 || k == 15 || k == 17) ? 4'b1000 : 4'b0000)) begin
                failures++; $display("FAIL reload_expire k=%0d got=%b", k, expire_a);
            end
        end
        we_a = 1'b0;
        wr_a(4'd12, 16'h0);
        wr_a(4'd15, 16'h1);
    endtask

    task automatic test_presc_reset_stop();
        bit found;
        int n;
        wr_b(4'd9, 16'd5);
        wr_b(4'd8, 16'h1);
        addr_b = 4'd10;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (rdata_b === 16'd4) found = 1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL presc_first_dec timeout got=%h exp=4", rdata_b);
        end
        n = 0;
        while (rdata_b !== 16'd3 && n < 8) begin
            step();
            n++;
        end
        checks++;
        if (n != 4) begin
            failures++; $display("FAIL presc_interval got=%0d exp=4", n);
        end
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        checks++;
        if (rdata_b !== 16'h0 || expire_b !== 3'h0 || irq_b !== 1'b0) begin
            failures++;
            $display("FAIL midreset_out got=%h/%b/%b exp=0/0/0", rdata_b, expire_b, irq_b);
        end
        for (int a = 0; a < 12; a++) begin
            addr_b = 4'(a);
            exp_q.push_back(16'h0);
            step();
            e = exp_q.pop_front();
            checks++;
            if (rdata_b !== e || expire_b !== 3'h0 || irq_b !== 1'b0) begin
                failures++;
                $display("FAIL midreset_reg a=%0d got=%h/%b/%b exp=%h/0/0", a, rdata_b, expire_b, irq_b, e);
            end
        end
        wr_b(4'd9, 16'd5);
        wr_b(4'd8, 16'h1);
        addr_b = 4'd10;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (rdata_b === 16'd4) found = 1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL restart_dec timeout got=%h exp=4", rdata_b);
        end
        wr_b(4'd8, 16'h0);
        addr_b = 4'd10;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(16'd4);
            step();
            e = exp_q.pop_front();
            checks++;
            if (rdata_b !== e || expire_b !== 3'h0) begin
                failures++; $display("FAIL stop_freeze k=%0d got=%h/%b exp=%h/0", k, rdata_b, expire_b, e);
            end
        end
    endtask

    task automatic test_addr_ro();
        wr_b(4'd1, 16'h0055);
        wr_b(4'd13, 16'h00AA);
        for (int a = 12; a < 16; a++) begin
            addr_b = 4'(a);
            exp_q.push_back(16'h0);
            step();
            e = exp_q.pop_front();
            checks++;
            if (rdata_b !== e) begin
                failures++; $display("FAIL oor_read a=%0d got=%h exp=%h", a, rdata_b, e);
            end
        end
        wr_b(4'd10, 16'h1234);
        addr_b = 4'd10;
        step();
        checks++;
        if (rdata_b !== 16'd4) begin
            failures++; $display("FAIL count_ro got=%h exp=0004", rdata_b);
        end
        wr_b(4'd1, 16'h0066);
        checks++;
        if (rdata_b !== 16'h0055) begin
            failures++; $display("FAIL rw_same_cycle got=%h exp=0055", rdata_b);
        end
        addr_b = 4'd1;
        step();
        checks++;
        if (rdata_b !== 16'h0066) begin
            failures++; $display("FAIL load_write got=%h exp=0066", rdata_b);
        end
    endtask

    initial begin
        rst_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        rst_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_reload();
        test_presc_reset_stop();
        test_addr_ro();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Parametrised multi-channel down-counting timer for the CPU's memory-mapped peripheral space.
- Each channel has two modes: one-shot and periodic auto-reload.
- All channels share one prescaler. Each channel has a load register, a live count readback, a sticky expiry flag and an interrupt enable.
- A single combined irq goes to the CPU, and per-channel expire pulses go to other fabric logic.

Parameters:
- NUM_CH, 4, number of independent timer channels (1..8).
- WIDTH, 16, counter, load and data-bus width in bits (8..32).
- PRESC_DIV, 1, shared prescaler divisor; one tick every PRESC_DIV clk cycles (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- we  input  1  register write strobe, sampled on clk rising edge.
- addr  input  $clog2(NUM_CH)+2  register address = {channel, reg_sel[1:0]}.
- wdata  input  WIDTH  write data.
- rdata  output  WIDTH  registered read data, valid 1 cycle after addr is presented.
- expire  output  NUM_CH  one-cycle pulse per channel on expiry.
- irq  output  1  registered OR over channels of (pending & ie).

Behaviour:
- Reset (rst=0 at an edge) clears all of the following to 0: prescaler, every channel's CTRL, LOAD, COUNT and pending, rdata, expire, irq. All channels enter IDLE. Reset mid-count aborts immediately with no expire pulse.
- Register map per channel (reg_sel):
  - 0 CTRL (rw): bit0 en, bit1 mode (0 one-shot, 1 periodic), bit2 ie; other bits read 0.
  - 1 LOAD (rw).
  - 2 COUNT (ro; writes ignored).
  - 3 STATUS: bit0 pending; writing 1 clears it, writing 0 has no effect.
- Addresses with channel >= NUM_CH read 0; writes to them are ignored.
- Prescaler:
  - Free-running 0..PRESC_DIV-1.
  - tick=1 in the cycle where the prescaler equals PRESC_DIV-1, then it wraps to 0.
  - PRESC_DIV=1 gives tick every cycle.
- Channel FSM states: IDLE, RUN.
  - IDLE -> RUN: CTRL write with en=1. COUNT<=LOAD on that same edge. Any prescaler tick on that edge is ignored.
  - RUN, tick, COUNT!=0: COUNT<=COUNT-1.
  - RUN, tick, COUNT==0: expire[ch] pulses high for the next cycle and pending<=1.
    - Periodic mode: COUNT<=LOAD, stay in RUN.
    - One-shot mode: en<=0, go to IDLE, COUNT stays 0.
  - RUN -> IDLE: CTRL write with en=0. COUNT holds its value and no expire occurs.
- Period is LOAD+1 ticks. LOAD=0 in periodic mode expires on every tick.
- A CTRL write with en=1 while already in RUN updates mode/ie only and does not restart the count.
- A LOAD write while in RUN takes effect at the next reload only.
- Pending set and a STATUS clear on the same edge: set wins, pending stays 1.
- irq is registered from pending & ie, so it lags pending by 1 cycle. Clearing ie masks irq without clearing pending.
- Read/write to the same register in the same cycle: rdata returns the old value.
- Counter arithmetic is unsigned WIDTH-bit. A decrement from 0 never occurs because 0 always triggers expiry.

Decomposition:
- Package timer_pkg holds:
  - reg_sel constants CTRL=0, LOAD=1, COUNT=2, STATUS=3;
  - CTRL bit indices EN=0, MODE=1, IE=2;
  - channel state enum {IDLE, RUN}.
- Sub-module timer_channel (WIDTH parameter) implements one channel's registers and FSM and exports count, ctrl, pending and expire.
- timer_multi contains the prescaler, address decode, read mux, NUM_CH timer_channel instances (generate) and the irq reduction.

Test Plan:
- PRESC_DIV=1, ch0:
  - Stimulus: LOAD=3, then CTRL=0x1 (one-shot) at edge T.
  - Required: COUNT reads 3,2,1,0; expire[0] high only in the cycle after edge T+4; en reads 0; pending=1; irq stays 0 (ie=0).
- PRESC_DIV=1, ch1:
  - Stimulus: LOAD=2, CTRL=0x7 (periodic, ie).
  - Required: expire[1] pulses every 3 cycles; irq=1 one cycle after the first pending.
  - Stimulus: write STATUS=1 on a non-expiry edge.
  - Required: pending=0, and irq drops 1 cycle later.
- Pending set/clear collision:
  - Stimulus: STATUS=1 write coincides with a ch1 expiry edge.
  - Required: pending remains 1.
- Reset and stop behaviour, PRESC_DIV=4, ch2:
  - Stimulus: LOAD=5, start.
  - Required: COUNT decrements once per 4 cycles.
  - Stimulus: rst=0 for 1 cycle while COUNT=3.
  - Required: all registers read 0, no expire, irq=0.
  - Stimulus: restart, then CTRL=0x0 mid-count.
  - Required: COUNT freezes.
- Reload and restart rules, ch3 periodic, LOAD=10:
  - Stimulus: write LOAD=1 while running.
  - Required: current period completes with 11 ticks, then period is 2 ticks.
  - Stimulus: CTRL en=1 rewrite while in RUN.
  - Required: no count restart.
- Address range and read-only registers, NUM_CH=3:
  - Stimulus: read addr {3,*}.
  - Required: rdata=0.
  - Stimulus: write to COUNT.
  - Required: COUNT unchanged.
